// File: rtl/fifo_pkg.sv
// Shared definitions for the 8-entry FIFO: state encoding (also used by the
// status-flag decoder) and default geometry.
package fifo_pkg;

    localparam int unsigned FIFO_DEPTH      = 8;
    localparam int unsigned FIFO_DATA_WIDTH = 32;
    localparam int unsigned FIFO_PTR_WIDTH  = 3;
    localparam int unsigned FIFO_CNT_WIDTH  = FIFO_PTR_WIDTH + 1;

    typedef enum logic [2:0] {
        IDLE     = 3'b000,
        WRITE    = 3'b001,
        READ     = 3'b010,
        WR_ERROR = 3'b011,
        RD_ERROR = 3'b100
    } fifo_state_e;

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: register file with a synchronous write port and a
// combinational read port. Contents are deliberately not reset.
module fifo_mem #(
    parameter int unsigned DEPTH      = fifo_pkg::FIFO_DEPTH,
    parameter int unsigned DATA_WIDTH = fifo_pkg::FIFO_DATA_WIDTH,
    parameter int unsigned PTR_WIDTH  = fifo_pkg::FIFO_PTR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [PTR_WIDTH-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [PTR_WIDTH-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO control core: decodes wr_en/rd_en against occupancy, advances the
// head/tail pointers and count, and registers read data and FSM state.
module fifo_ctrl #(
    parameter int unsigned DEPTH      = fifo_pkg::FIFO_DEPTH,
    parameter int unsigned DATA_WIDTH = fifo_pkg::FIFO_DATA_WIDTH,
    parameter int unsigned PTR_WIDTH  = fifo_pkg::FIFO_PTR_WIDTH,
    parameter int unsigned CNT_WIDTH  = fifo_pkg::FIFO_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [2:0]            state,
    output logic [CNT_WIDTH-1:0]  data_count
);

    import fifo_pkg::*;

    fifo_state_e           state_q, state_d;
    logic [PTR_WIDTH-1:0]  head_q, head_d;
    logic [PTR_WIDTH-1:0]  tail_q, tail_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    fifo_mem #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .PTR_WIDTH  (PTR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (tail_q),
        .wdata (din),
        .raddr (head_q),
        .rdata (mem_rdata)
    );

    // Simultaneous wr_en/rd_en falls through to IDLE: both requests are dropped.
    always_comb begin
        state_d = IDLE;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        dout_d  = dout_q;
        mem_we  = 1'b0;
        if (wr_en && !rd_en) begin
            if (count_q == CNT_WIDTH'(DEPTH)) begin
                state_d = WR_ERROR;
            end else begin
                state_d = WRITE;
                mem_we  = 1'b1;
                tail_d  = tail_q + PTR_WIDTH'(1);
                count_d = count_q + CNT_WIDTH'(1);
            end
        end else if (rd_en && !wr_en) begin
            if (count_q == '0) begin
                state_d = RD_ERROR;
            end else begin
                state_d = READ;
                dout_d  = mem_rdata;
                head_d  = head_q + PTR_WIDTH'(1);
                count_d = count_q - CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            dout_q  <= dout_d;
        end
    end

    assign state      = state_q;
    assign data_count = count_q;
    assign dout       = dout_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: queue-based reference model checked every cycle, plus
// directed literal checks at the interesting points.
module tb_fifo_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] din = '0;
    logic [31:0] dout;
    logic [2:0]  state;
    logic [3:0]  data_count;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic [31:0] q[$];
    int          m_state = 0;
    logic [31:0] m_dout = '0;

    always #5 clk = ~clk;

    fifo_ctrl #(
        .DEPTH      (8),
        .DATA_WIDTH (32),
        .PTR_WIDTH  (3),
        .CNT_WIDTH  (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .din        (din),
        .dout       (dout),
        .state      (state),
        .data_count (data_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_state = 0;
        m_dout  = '0;
    endtask

    // Drive one request, let the edge sample it, advance the model.
    task automatic step(input logic w, input logic r, input logic [31:0] d);
        wr_en = w;
        rd_en = r;
        din   = d;
        @(posedge clk);
        if (w && !r) begin
            if (q.size() < 8) begin
                q.push_back(d);
                m_state = 1;
            end else begin
                m_state = 3;
            end
        end else if (r && !w) begin
            if (q.size() > 0) begin
                m_dout  = q.pop_front();
                m_state = 2;
            end else begin
                m_state = 4;
            end
        end else begin
            m_state = 0;
        end
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_state", 32'(state), 32'(m_state));
            chk("model_count", 32'(data_count), 32'(q.size()));
            chk("model_dout", dout, m_dout);
        end
    end

    initial begin
        model_reset();
        @(posedge clk);
        chk_en = 1'b1;
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset then idle
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'hDEAD);
        chk("idle_state", 32'(state), 32'h0);
        chk("idle_count", 32'(data_count), 32'h0);

        // Fill
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 32'(i));
        chk("fill_count", 32'(data_count), 32'd8);
        chk("fill_state", 32'(state), 32'd1);
        step(1'b1, 1'b0, 32'h99);
        chk("overflow_state", 32'(state), 32'd3);
        chk("overflow_count", 32'(data_count), 32'd8);

        // Drain
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1, 32'h0);
            chk("drain_dout", dout, 32'(i));
        end
        chk("drain_count", 32'(data_count), 32'd0);
        step(1'b0, 1'b1, 32'h0);
        chk("underflow_state", 32'(state), 32'd4);
        chk("underflow_dout", dout, 32'd8);

        // Wrap-around
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h10 + 32'(i));
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 32'h0);
        chk("pre_wrap_dout", dout, 32'h14);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'hA0 + 32'(i));
        chk("wrap_full_state", 32'(state), 32'd1);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 32'h0);
            chk("wrap_dout", dout, 32'hA0 + 32'(i));
        end

        // Simultaneous request
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'hB0 + 32'(i));
        step(1'b1, 1'b1, 32'hFF);
        chk("both_state", 32'(state), 32'd0);
        chk("both_count", 32'(data_count), 32'd3);
        chk("both_dout", dout, 32'hA7);
        step(1'b0, 1'b1, 32'h0);
        chk("after_both_dout", dout, 32'hB0);
        step(1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b1, 32'h0);

        // Async reset between edges
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'hC0 + 32'(i));
        chk("pre_rst_count", 32'(data_count), 32'd4);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("async_state", 32'(state), 32'd0);
        chk("async_count", 32'(data_count), 32'd0);
        chk("async_dout", dout, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        step(1'b0, 1'b1, 32'h0);
        chk("post_rst_state", 32'(state), 32'd4);
        chk("post_rst_count", 32'(data_count), 32'd0);
        step(1'b1, 1'b0, 32'hE1);
        step(1'b0, 1'b1, 32'h0);
        chk("post_rst_dout", dout, 32'hE1);

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
Sequential control and storage core of the 8-entry FIFO. It accepts wr_en/rd_en requests and updates the head/tail pointers, data_count and the FSM state. It drives the state[2:0] and data_count[3:0] buses that the FIFO status-flag decoder consumes to generate full/empty/wr_ack/wr_err/rd_ack/rd_err.

Parameters:
DEPTH, 8, number of entries; must be a power of two.
DATA_WIDTH, 32, width of din/dout.
PTR_WIDTH, 3, log2(DEPTH); head/tail pointer width.
CNT_WIDTH, 4, PTR_WIDTH+1; data_count width.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
wr_en  input  1  write request for this cycle
rd_en  input  1  read request for this cycle
din  input  DATA_WIDTH  write data, sampled when a write is accepted
dout  output  DATA_WIDTH  read data, registered
state  output  3  registered FSM state, encoding below
data_count  output  CNT_WIDTH  registered occupancy, range 0..DEPTH

Behaviour:
- Reset (reset_n=0, takes effect immediately, independent of clk):
  - state=IDLE, data_count=0, head=0, tail=0, dout=0.
  - Storage contents are not reset.
- State encoding, shared with the flag decoder: IDLE=3'b000, WRITE=3'b001, READ=3'b010, WR_ERROR=3'b011, RD_ERROR=3'b100. Codes 101..111 are never produced.
- Next state is decided from wr_en, rd_en and the current data_count:
  - wr_en=1, rd_en=0, data_count<DEPTH -> WRITE. mem[tail]<=din; tail<=tail+1 (mod DEPTH); data_count<=data_count+1.
  - wr_en=1, rd_en=0, data_count==DEPTH -> WR_ERROR. No pointer, count or storage change.
  - rd_en=1, wr_en=0, data_count>0 -> READ. dout<=mem[head]; head<=head+1 (mod DEPTH); data_count<=data_count-1.
  - rd_en=1, wr_en=0, data_count==0 -> RD_ERROR. No pointer or count change; dout holds.
  - wr_en=rd_en=0 -> IDLE, no change.
  - wr_en=rd_en=1 (simultaneous request) -> IDLE, no change. Both requests are dropped and the requester must retry.
- Latency: a request sampled at edge N is reflected in state, data_count and dout immediately after edge N. Each state lasts exactly one cycle per request, so consecutive WRITE or READ cycles are allowed.
- dout changes only on an accepted READ and otherwise holds its last value.
- Pointer wrap: tail and head roll from DEPTH-1 to 0 with no special handling. Full and empty are distinguished solely by data_count, never by pointer comparison.
- data_count never exceeds DEPTH and never goes below 0; the error states guarantee this.
- Reset asserted mid-burst discards all contents: count=0 and pointers=0 on release. The first cycle after reset_n rises behaves as if from IDLE.
- Storage write and read use the current-cycle pointers (tail/head before the increment).

Decomposition:
- Shared package fifo_pkg holds:
  - the five state localparams (IDLE..RD_ERROR), used by both fifo_ctrl and the flag decoder;
  - DEPTH, DATA_WIDTH, PTR_WIDTH and CNT_WIDTH defaults.
- One natural sub-module, fifo_mem: DEPTH x DATA_WIDTH register file with synchronous write (we, waddr, wdata) and a combinational read port (raddr -> rdata). fifo_ctrl registers rdata into dout on READ.
- The next-state/count logic stays in fifo_ctrl as a combinational block plus one register block.

Test Plan:
- Reset then idle: reset_n=0 for 2 cycles, release, hold wr_en=rd_en=0 -> state=000, data_count=0, dout=0 every cycle.
- Fill: 8 consecutive writes of din=1..8 -> state=001 each cycle, data_count=1..8. A 9th write gives state=011 with data_count staying 8.
- Drain: from full, 8 consecutive reads -> state=010, dout=1..8 in order, data_count 7..0. A 9th read gives state=100, data_count=0, dout holds 8.
- Wrap-around: write 5, read 5, then write 8 values 0xA0..0xA7 and read 8 -> dout=0xA0..0xA7 in order. Pointers wrap past index 7 without corruption or spurious error.
- Simultaneous request: with data_count=3, assert wr_en=rd_en=1 for one cycle -> state=000, data_count stays 3, dout unchanged. Next single read returns the oldest entry.
- Async reset mid-operation: after 4 writes, pull reset_n low between clock edges -> state=000 and data_count=0 immediately, without waiting for a clock edge. After release, a read gives state=100.
